// File: rtl/fifo_read_streamer.sv
// Turns a FIFO with a registered read port into a valid/ready stream.
// A two-entry skid buffer absorbs the one-cycle read latency so a full-rate stream never stalls.
module fifo_read_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  enable,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    logic [1:0]            occ_q, occ_d;
    logic                  infl_q, infl_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  pop;
    logic                  push;
    logic [2:0]            lvl;

    always_comb begin
        pop    = (occ_q != 2'd0) && m_ready;
        push   = infl_q;
        // Words we will hold next cycle if nothing new is requested now.
        lvl    = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
        r_en   = rrst_n && enable && !empty && (lvl < 3'd2);
        infl_d = r_en;

        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;

        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = fifo_rdata;
                else               tail_d = fifo_rdata;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the arriving word goes behind whatever remains.
                if (occ_q == 2'd1) begin
                    head_d = fifo_rdata;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_rdata;
                end
            end
            default: ;
        endcase

        if (pop) cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ_q  <= 2'd0;
            infl_q <= 1'b0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            occ_q  <= occ_d;
            infl_q <= infl_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = head_q;
    assign word_cnt = cnt_q;

endmodule
